// File: rtl/wb_pkg.sv
// Shared constants, entry layout and destination helper for the register writeback queue.
package wb_pkg;

   localparam int unsigned DEPTH_DEFAULT = 4;
   localparam int unsigned DEST_W        = 5;
   localparam int unsigned DATA_W        = 32;

   localparam logic [DEST_W-1:0] REG_ZERO = 5'd0;
   localparam logic [DEST_W-1:0] REG_RA   = 5'd31;

   typedef struct packed {
      logic              valid;
      logic              ready;
      logic [DEST_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } entry_t;

   function automatic logic [DEST_W-1:0] entryDest(
      input logic              isJal,
      input logic              isRdOrRtWritten,
      input logic [DEST_W-1:0] rd,
      input logic [DEST_W-1:0] rt
   );
      if (isJal)
         return REG_RA;
      else if (isRdOrRtWritten)
         return rd;
      else
         return rt;
   endfunction

endpackage

// File: rtl/wb_forward_match.sv
// Youngest-match search over the queue entries for one forwarding lookup port.
module wb_forward_match
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic [DEST_W-1:0]        iLookupReg,
   input  logic [$clog2(DEPTH)-1:0] iRdPtr,
   input  entry_t                   iEntries [DEPTH],
   output logic                     oHit,
   output logic                     oPending,
   output logic [DATA_W-1:0]        oData
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      oHit     = 1'b0;
      oPending = 1'b0;
      oData    = '0;
      idx      = '0;
      if (iLookupReg != REG_ZERO) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = iRdPtr + PTR_W'(i);
            if (iEntries[idx].valid && iEntries[idx].dest == iLookupReg) begin
               oHit     = 1'b1;
               oPending = !iEntries[idx].ready;
               oData    = iEntries[idx].ready ? iEntries[idx].data : '0;
            end
         end
      end
   end

endmodule

// File: rtl/register_writeback_queue.sv
// In-order register writeback queue with load-data fill and optional forwarding lookup.
// Define WB_FORWARD_EN to build the lookup logic; otherwise oFwd* are tied to 0.
module register_writeback_queue
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                     iCpuClock,
   input  logic                     iCpuReset,
   input  logic                     iEnqValid,
   output logic                     oEnqReady,
   input  logic [4:0]               iRd,
   input  logic [4:0]               iRt,
   input  logic                     iIsRdOrRtWritten,
   input  logic                     iIsJal,
   input  logic                     iIsRegFromMem,
   input  logic [31:0]              iAluResult,
   input  logic [31:0]              iJalLinkAddress,
   input  logic                     iMemValid,
   input  logic [31:0]              iMemoryData,
   output logic                     oRegWriteEn,
   output logic [4:0]               oRegWriteDest,
   output logic [31:0]              oRegWriteData,
   input  logic [4:0]               iLookupReg1,
   input  logic [4:0]               iLookupReg2,
   output logic                     oFwdHit1,
   output logic                     oFwdHit2,
   output logic                     oFwdPending1,
   output logic                     oFwdPending2,
   output logic [31:0]              oFwdData1,
   output logic [31:0]              oFwdData2,
   output logic [$clog2(DEPTH):0]   oCount,
   output logic                     oEmpty,
   output logic                     oFull,
   output logic                     oMemOrphan
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   entry_t           queue [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [CNT_W-1:0] count;
   logic             memOrphan;

   entry_t           headEntry;
   entry_t           newEntry;
   logic             full;
   logic             enqFire;
   logic             popFire;
   logic             fillHit;
   logic [PTR_W-1:0] fillIdx;
   logic [PTR_W-1:0] scanIdx;

   assign headEntry = queue[rdPtr];
   assign full      = (count == CNT_W'(DEPTH));
   assign enqFire   = iEnqValid && !full;
   assign popFire   = headEntry.valid && headEntry.ready;

   always_comb begin
      newEntry       = '0;
      newEntry.valid = 1'b1;
      newEntry.dest  = entryDest(iIsJal, iIsRdOrRtWritten, iRd, iRt);
      if (iIsJal) begin
         newEntry.ready = 1'b1;
         newEntry.data  = iJalLinkAddress;
      end else if (iIsRegFromMem) begin
         newEntry.ready = 1'b0;
         newEntry.data  = '0;
      end else begin
         newEntry.ready = 1'b1;
         newEntry.data  = iAluResult;
      end
   end

   // Oldest pending entry; only entries present before the edge are candidates.
   always_comb begin
      fillHit = 1'b0;
      fillIdx = '0;
      scanIdx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         scanIdx = rdPtr + PTR_W'(i);
         if (!fillHit && queue[scanIdx].valid && !queue[scanIdx].ready) begin
            fillHit = 1'b1;
            fillIdx = scanIdx;
         end
      end
   end

   always_ff @(posedge iCpuClock or posedge iCpuReset) begin
      if (iCpuReset) begin
         rdPtr     <= '0;
         wrPtr     <= '0;
         count     <= '0;
         memOrphan <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++)
            queue[i] <= '0;
      end else begin
         memOrphan <= iMemValid && !fillHit;
         // Pop, fill and enqueue never target the same slot in one edge.
         if (popFire) begin
            queue[rdPtr].valid <= 1'b0;
            queue[rdPtr].ready <= 1'b0;
            rdPtr              <= rdPtr + 1'b1;
         end
         if (iMemValid && fillHit) begin
            queue[fillIdx].ready <= 1'b1;
            queue[fillIdx].data  <= iMemoryData;
         end
         if (enqFire) begin
            queue[wrPtr] <= newEntry;
            wrPtr        <= wrPtr + 1'b1;
         end
         case ({enqFire, popFire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign oEnqReady     = !full;
   assign oFull         = full;
   assign oEmpty        = (count == '0);
   assign oCount        = count;
   assign oMemOrphan    = memOrphan;
   assign oRegWriteEn   = popFire && (headEntry.dest != REG_ZERO);
   assign oRegWriteDest = headEntry.valid ? headEntry.dest : '0;
   assign oRegWriteData = headEntry.valid ? headEntry.data : '0;

`ifdef WB_FORWARD_EN
   wb_forward_match #(.DEPTH(DEPTH)) uForwardMatch1 (
      .iLookupReg (iLookupReg1),
      .iRdPtr     (rdPtr),
      .iEntries   (queue),
      .oHit       (oFwdHit1),
      .oPending   (oFwdPending1),
      .oData      (oFwdData1)
   );

   wb_forward_match #(.DEPTH(DEPTH)) uForwardMatch2 (
      .iLookupReg (iLookupReg2),
      .iRdPtr     (rdPtr),
      .iEntries   (queue),
      .oHit       (oFwdHit2),
      .oPending   (oFwdPending2),
      .oData      (oFwdData2)
   );
`else
   logic unusedLookup;
   assign unusedLookup = ^{iLookupReg1, iLookupReg2};
   assign oFwdHit1     = 1'b0;
   assign oFwdHit2     = 1'b0;
   assign oFwdPending1 = 1'b0;
   assign oFwdPending2 = 1'b0;
   assign oFwdData1    = '0;
   assign oFwdData2    = '0;
`endif

endmodule

// File: tb/tb_register_writeback_queue.sv
// Randomized and directed bench for register_writeback_queue against a queue-based reference model.
module tb_register_writeback_queue;

   localparam int unsigned DEPTH = 4;

   logic        iCpuClock;
   logic        iCpuReset;
   logic        iEnqValid;
   logic        oEnqReady;
   logic [4:0]  iRd;
   logic [4:0]  iRt;
   logic        iIsRdOrRtWritten;
   logic        iIsJal;
   logic        iIsRegFromMem;
   logic [31:0] iAluResult;
   logic [31:0] iJalLinkAddress;
   logic        iMemValid;
   logic [31:0] iMemoryData;
   logic        oRegWriteEn;
   logic [4:0]  oRegWriteDest;
   logic [31:0] oRegWriteData;
   logic [4:0]  iLookupReg1;
   logic [4:0]  iLookupReg2;
   logic        oFwdHit1;
   logic        oFwdHit2;
   logic        oFwdPending1;
   logic        oFwdPending2;
   logic [31:0] oFwdData1;
   logic [31:0] oFwdData2;
   logic [2:0]  oCount;
   logic        oEmpty;
   logic        oFull;
   logic        oMemOrphan;

   register_writeback_queue #(.DEPTH(DEPTH)) dut (
      .iCpuClock        (iCpuClock),
      .iCpuReset        (iCpuReset),
      .iEnqValid        (iEnqValid),
      .oEnqReady        (oEnqReady),
      .iRd              (iRd),
      .iRt              (iRt),
      .iIsRdOrRtWritten (iIsRdOrRtWritten),
      .iIsJal           (iIsJal),
      .iIsRegFromMem    (iIsRegFromMem),
      .iAluResult       (iAluResult),
      .iJalLinkAddress  (iJalLinkAddress),
      .iMemValid        (iMemValid),
      .iMemoryData      (iMemoryData),
      .oRegWriteEn      (oRegWriteEn),
      .oRegWriteDest    (oRegWriteDest),
      .oRegWriteData    (oRegWriteData),
      .iLookupReg1      (iLookupReg1),
      .iLookupReg2      (iLookupReg2),
      .oFwdHit1         (oFwdHit1),
      .oFwdHit2         (oFwdHit2),
      .oFwdPending1     (oFwdPending1),
      .oFwdPending2     (oFwdPending2),
      .oFwdData1        (oFwdData1),
      .oFwdData2        (oFwdData2),
      .oCount           (oCount),
      .oEmpty           (oEmpty),
      .oFull            (oFull),
      .oMemOrphan       (oMemOrphan)
   );

   initial iCpuClock = 1'b0;
   always #5 iCpuClock = ~iCpuClock;

   typedef struct {
      logic [4:0]  dest;
      logic [31:0] data;
      bit          ready;
   } modelEntry_t;

   modelEntry_t modelQ [$];
   bit          expOrphan;
   int          checkCount = 0;
   int          errorCount = 0;

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic idle();
      iEnqValid        = 1'b0;
      iRd              = '0;
      iRt              = '0;
      iIsRdOrRtWritten = 1'b0;
      iIsJal           = 1'b0;
      iIsRegFromMem    = 1'b0;
      iAluResult       = '0;
      iJalLinkAddress  = '0;
      iMemValid        = 1'b0;
      iMemoryData      = '0;
   endtask

   task automatic setEnq(input logic [4:0] rd, input logic [4:0] rt, input logic wr, input logic jal,
                         input logic mem, input logic [31:0] alu, input logic [31:0] link);
      iEnqValid        = 1'b1;
      iRd              = rd;
      iRt              = rt;
      iIsRdOrRtWritten = wr;
      iIsJal           = jal;
      iIsRegFromMem    = mem;
      iAluResult       = alu;
      iJalLinkAddress  = link;
   endtask

   // Youngest matching entry wins; pending data reads as zero.
   function automatic void fwdModel(input logic [4:0] lookupReg, output logic hit,
                                    output logic pending, output logic [31:0] data);
      hit = 1'b0;
      pending = 1'b0;
      data = '0;
`ifdef WB_FORWARD_EN
      if (lookupReg != 5'd0) begin
         for (int i = modelQ.size() - 1; i >= 0; i--) begin
            if (modelQ[i].dest == lookupReg) begin
               hit = 1'b1;
               pending = !modelQ[i].ready;
               data = modelQ[i].ready ? modelQ[i].data : 32'd0;
               break;
            end
         end
      end
`endif
   endfunction

   task automatic checkOutputs();
      logic        hit;
      logic        pend;
      logic [31:0] data;
      bit          headValid;
      headValid = modelQ.size() > 0;
      checkValue("count", 32'(oCount), 32'(modelQ.size()));
      checkValue("empty", 32'(oEmpty), 32'(modelQ.size() == 0));
      checkValue("full", 32'(oFull), 32'(modelQ.size() == DEPTH));
      checkValue("enqReady", 32'(oEnqReady), 32'(modelQ.size() != DEPTH));
      checkValue("memOrphan", 32'(oMemOrphan), 32'(expOrphan));
      checkValue("regWriteEn", 32'(oRegWriteEn),
                 32'(headValid && modelQ[0].ready && modelQ[0].dest != 5'd0));
      checkValue("regWriteDest", 32'(oRegWriteDest), headValid ? 32'(modelQ[0].dest) : 32'd0);
      checkValue("regWriteData", oRegWriteData, headValid ? modelQ[0].data : 32'd0);
      fwdModel(iLookupReg1, hit, pend, data);
      checkValue("fwdHit1", 32'(oFwdHit1), 32'(hit));
      checkValue("fwdPending1", 32'(oFwdPending1), 32'(pend));
      checkValue("fwdData1", oFwdData1, data);
      fwdModel(iLookupReg2, hit, pend, data);
      checkValue("fwdHit2", 32'(oFwdHit2), 32'(hit));
      checkValue("fwdPending2", 32'(oFwdPending2), 32'(pend));
      checkValue("fwdData2", oFwdData2, data);
   endtask

   task automatic modelEdge();
      bit          doPop;
      bit          doEnq;
      int          fillAt;
      modelEntry_t e;
      doPop  = modelQ.size() > 0 && modelQ[0].ready;
      doEnq  = iEnqValid && modelQ.size() < DEPTH;
      fillAt = -1;
      foreach (modelQ[i])
         if (fillAt < 0 && !modelQ[i].ready) fillAt = i;
      expOrphan = iMemValid && fillAt < 0;
      if (iMemValid && fillAt >= 0) begin
         modelQ[fillAt].ready = 1'b1;
         modelQ[fillAt].data  = iMemoryData;
      end
      if (doEnq) begin
         e.dest  = iIsJal ? 5'd31 : (iIsRdOrRtWritten ? iRd : iRt);
         e.ready = iIsJal || !iIsRegFromMem;
         e.data  = iIsJal ? iJalLinkAddress : (iIsRegFromMem ? 32'd0 : iAluResult);
      end
      if (doPop) void'(modelQ.pop_front());
      if (doEnq) modelQ.push_back(e);
   endtask

   // Inputs are driven at the negedge before this is called.
   task automatic cycle();
      #1;
      checkOutputs();
      @(posedge iCpuClock);
      modelEdge();
      @(negedge iCpuClock);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkValue({tag, "_count"}, 32'(oCount), 32'd0);
      checkValue({tag, "_empty"}, 32'(oEmpty), 32'd1);
      checkValue({tag, "_full"}, 32'(oFull), 32'd0);
      checkValue({tag, "_enqReady"}, 32'(oEnqReady), 32'd1);
      checkValue({tag, "_writeEn"}, 32'(oRegWriteEn), 32'd0);
      checkValue({tag, "_writeData"}, oRegWriteData, 32'd0);
      checkValue({tag, "_orphan"}, 32'(oMemOrphan), 32'd0);
      checkValue({tag, "_fwdHit1"}, 32'(oFwdHit1), 32'd0);
   endtask

   initial begin
      iCpuReset   = 1'b1;
      iLookupReg1 = 5'd3;
      iLookupReg2 = 5'd9;
      idle();
      expOrphan = 1'b0;
      #3;
      checkResetOutputs("initReset");
      @(negedge iCpuClock);
      iCpuReset = 1'b0;

      // Single ALU write to r5
      setEnq(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 32'h1234, 32'd0);
      cycle();
      idle();
      #1;
      checkValue("alu_writeEn", 32'(oRegWriteEn), 32'd1);
      checkValue("alu_dest", 32'(oRegWriteDest), 32'd5);
      checkValue("alu_data", oRegWriteData, 32'h0000_1234);
      cycle();
      checkValue("alu_emptyAfter", 32'(oEmpty), 32'd1);
      cycle();

      // Load to r8 then ALU r9, released by memory data
      setEnq(5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      cycle();
      setEnq(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0);
      cycle();
      idle();
      cycle();
      cycle();
      iMemValid   = 1'b1;
      iMemoryData = 32'hCAFE_BABE;
      cycle();
      idle();
      #1;
      checkValue("load_r8Dest", 32'(oRegWriteDest), 32'd8);
      checkValue("load_r8Data", oRegWriteData, 32'hCAFE_BABE);
      cycle();
      checkValue("load_r9Dest", 32'(oRegWriteDest), 32'd9);
      checkValue("load_r9En", 32'(oRegWriteEn), 32'd1);
      cycle();
      cycle();

      // Five enqueues behind a pending head, fifth dropped
      for (int i = 0; i < 5; i++) begin
         setEnq(5'd0, 5'(i + 1), 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
         cycle();
      end
      idle();
      #1;
      checkValue("full_count", 32'(oCount), 32'd4);
      checkValue("full_flag", 32'(oFull), 32'd1);
      checkValue("full_enqReady", 32'(oEnqReady), 32'd0);
      for (int i = 0; i < 4; i++) begin
         iMemValid   = 1'b1;
         iMemoryData = 32'h100 + 32'(i);
         cycle();
      end
      idle();
      repeat (5) cycle();

      // Forwarding: youngest r3 wins, then a pending load to r3
      setEnq(5'd0, 5'd10, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      cycle();
      setEnq(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
      cycle();
      setEnq(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
      cycle();
      idle();
`ifdef WB_FORWARD_EN
      #1;
      checkValue("fwd_youngHit", 32'(oFwdHit1), 32'd1);
      checkValue("fwd_youngData", oFwdData1, 32'd2);
`endif
      setEnq(5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      cycle();
      idle();
`ifdef WB_FORWARD_EN
      #1;
      checkValue("fwd_pending", 32'(oFwdPending1), 32'd1);
      checkValue("fwd_pendingData", oFwdData1, 32'd0);
`endif
      iMemValid   = 1'b1;
      iMemoryData = 32'hAAAA_0001;
      cycle();
      iMemoryData = 32'hAAAA_0002;
      cycle();
      idle();
      repeat (6) cycle();

      // JAL link write and a silently popped destination-0 entry
      setEnq(5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 32'hDEAD, 32'h0040_0008);
      cycle();
      setEnq(5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h55, 32'd0);
      idle();
      #1;
      checkValue("jal_dest", 32'(oRegWriteDest), 32'd31);
      checkValue("jal_data", oRegWriteData, 32'h0040_0008);
      setEnq(5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h55, 32'd0);
      cycle();
      idle();
      cycle();
      checkValue("zero_emptyAfter", 32'(oEmpty), 32'd1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         iEnqValid        = ($urandom_range(0, 2) != 0);
         iRd              = 5'($urandom_range(0, 7));
         iRt              = 5'($urandom_range(0, 7));
         iIsRdOrRtWritten = 1'($urandom);
         iIsJal           = ($urandom_range(0, 7) == 0);
         iIsRegFromMem    = ($urandom_range(0, 2) == 0);
         iAluResult       = $urandom;
         iJalLinkAddress  = $urandom;
         iMemValid        = ($urandom_range(0, 3) == 0);
         iMemoryData      = $urandom;
         iLookupReg1      = 5'($urandom_range(0, 7));
         iLookupReg2      = 5'($urandom_range(0, 7));
         cycle();
      end
      idle();
      repeat (4) begin
         iMemValid   = 1'b1;
         iMemoryData = $urandom;
         cycle();
      end
      idle();
      repeat (6) cycle();

      // Asynchronous reset with entries queued, then an orphan fill
      for (int i = 0; i < 3; i++) begin
         setEnq(5'd0, 5'(i + 12), 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
         cycle();
      end
      idle();
      #1;
      checkValue("rst_preCount", 32'(oCount), 32'd3);
      #1;
      iCpuReset = 1'b1;
      #1;
      checkResetOutputs("asyncReset");
      modelQ.delete();
      expOrphan = 1'b0;
      @(negedge iCpuClock);
      iCpuReset = 1'b0;
      iMemValid = 1'b1;
      iMemoryData = 32'h1111_2222;
      cycle();
      idle();
      #1;
      checkValue("orphan_pulse", 32'(oMemOrphan), 32'd1);
      cycle();
      checkValue("orphan_cleared", 32'(oMemOrphan), 32'd0);
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/register_writeback_queue.md
REGISTER_WRITEBACK_QUEUE -- requirements
Module: register_writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of 2, 2..16).
REQ-002 SHALL have port iCpuClock, input, 1 bit, the CPU clock; all state changes on its rising edge.
REQ-003 SHALL have port iCpuReset, input, 1 bit, the reset: asynchronous, active-high.
REQ-004 SHALL have ports iEnqValid (in 1) and oEnqReady (out 1), the write-request handshake.
REQ-005 SHALL have enqueue inputs iRd (5), iRt (5), iIsRdOrRtWritten (1), iIsJal (1), iIsRegFromMem (1), iAluResult (32) and iJalLinkAddress (32).
REQ-006 SHALL have ports iMemValid (in 1) and iMemoryData (in 32), the load-data return.
REQ-007 SHALL have ports oRegWriteEn (out 1), oRegWriteDest (out 5) and oRegWriteData (out 32), the register-file write port.
REQ-008 SHALL have ports iLookupReg1 (in 5), iLookupReg2 (in 5), oFwdHit1/2 (out 1), oFwdPending1/2 (out 1) and oFwdData1/2 (out 32), the forwarding lookup.
REQ-009 SHALL have ports oCount (out log2(DEPTH)+1), oEmpty (out 1), oFull (out 1) and oMemOrphan (out 1).

Function
REQ-010 SHALL assert oEnqReady = !oFull; enqueue occurs on an edge with iEnqValid && oEnqReady; iEnqValid while full is ignored and nothing is stored.
REQ-011 SHALL compute the entry destination as: 31 if iIsJal; else iRd if iIsRdOrRtWritten; else iRt.
REQ-012 SHALL compute the entry data as: iJalLinkAddress if iIsJal (data ready); else if iIsRegFromMem, data pending with value 0; else iAluResult (data ready).
REQ-013 SHALL, on an edge with iMemValid, write iMemoryData into the oldest pending entry and mark it ready; with no pending entry, nothing changes and oMemOrphan pulses high for exactly the next cycle.
REQ-014 SHALL drive oRegWriteEn combinationally high when the head entry is valid, ready and has destination != 0; oRegWriteDest/oRegWriteData equal the head fields.
REQ-015 SHALL pop the head on the edge in which it is valid and ready, including destination-0 entries, which are popped silently with oRegWriteEn=0; at most one pop per cycle.
REQ-016 SHALL give a minimum latency of one cycle: an entry enqueued at edge N appears on the write port in cycle N+1 when it is head and ready; there is no same-cycle enqueue-to-write bypass.
REQ-017 SHALL, on a simultaneous enqueue and pop, perform both, leaving oCount unchanged; a pop does not free a slot for a same-edge enqueue while full.
REQ-018 SHALL, on an iMemValid fill of the head on edge N, retire that entry no earlier than cycle N+1.
REQ-019 SHALL wrap the read and write pointers modulo DEPTH; oCount ranges 0..DEPTH; oEmpty = (oCount==0); oFull = (oCount==DEPTH).
REQ-020 SHALL, for each lookup port, select the youngest valid entry whose destination equals the lookup register (!= 0); oFwdHit=1; oFwdPending = !ready; oFwdData = entry data, or 0 if pending.
REQ-021 SHALL, for each lookup port with no match or a lookup of register 0, drive oFwdHit=0, oFwdPending=0 and oFwdData=0.
REQ-022 SHALL evaluate lookups combinationally against the state before the current edge; the head retiring this cycle still matches.

Reset
REQ-023 SHALL, on iCpuReset, clear pointers, oCount, all valid/ready flags and oMemOrphan immediately without waiting for a clock; all outputs read 0 except oEmpty=1 and oEnqReady=1.
REQ-024 SHALL discard in-flight and pending entries on reset mid-operation; an iMemValid in the first edge after reset release produces oMemOrphan.

Configuration
REQ-025 SHALL, with macro WB_FORWARD_EN defined, implement REQ-020..REQ-022.
REQ-026 SHALL, with WB_FORWARD_EN undefined, omit the lookup logic and tie all oFwd* outputs to 0; the lookup inputs are unused; the queue behaviour is otherwise identical.

Structure
REQ-027 SHALL place REG_ZERO=5'd0, REG_RA=5'd31, DEPTH_DEFAULT=4 and the entry field widths (dest 5, data 32, flags valid/ready) in the shared package wb_pkg.
REQ-028 SHALL implement the youngest-match priority search in the single sub-module wb_forward_match, instantiated once per lookup port and only under WB_FORWARD_EN.

Verification
REQ-029 SHALL cover: enqueue ALU op rd=5, data 0x1234, iIsRdOrRtWritten=1 -> the next cycle oRegWriteEn=1, dest 5, data 0x00001234, then oEmpty=1.
REQ-030 SHALL cover: enqueue load rt=8 followed by ALU rd=9 data 7 -> no write until iMemValid with data 0xCAFEBABE; then the r8 write is followed by the r9 write in consecutive cycles.
REQ-031 SHALL cover: 5 enqueues with DEPTH=4 and a pending head -> oFull=1, oEnqReady=0, the 5th enqueue is dropped and oCount=4.
REQ-032 SHALL cover: entries r3=1 and r3=2 queued, lookup 3 -> oFwdHit1=1 and data 2; a pending load to r3 queued youngest -> oFwdPending1=1 and data 0.
REQ-033 SHALL cover: a JAL enqueue with link 0x00400008 -> write to dest 31 with 0x00400008; an enqueue to dest 0 -> popped with no oRegWriteEn.
REQ-034 SHALL cover: reset asserted with 3 entries queued -> outputs cleared with no clock edge; a following iMemValid -> oMemOrphan=1 for one cycle.
